regs_xfer_sequencer: RTL and testbench

//  Upstream driver of the register/bus file. Queues register-transfer micro-ops (src, dst, immed).

---
 rtl/regs_xfer_sequencer_if.sv | 53 +++++
 rtl/regs_xfer_sequencer.sv | 153 +++++++++++++++
 tb/tb_regs_xfer_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/regs_xfer_sequencer_if.sv
// Shared types for the register-transfer sequencer plus the interface that
// bundles the decoder-side handshake and the regs-side bus drive.
// master: microcode decoder / driver side.  slave: the sequencer itself.

package regs_xfer_pkg;

    // Bus endpoints of the register file; REG_ALU and REG_IMM are source-only.
    typedef enum logic [3:0] {
        REG_A, REG_B, REG_XL, REG_XH, REG_YL, REG_YH, REG_SPL, REG_SPH,
        REG_MX, REG_MY, REG_MSP, REG_MN, REG_ALU, REG_IMM
    } reg_type;

    typedef enum logic [1:0] {
        CYCLE_NONE, CYCLE_REG_FETCH, CYCLE_REG_WRITE
    } microcode_cycle;

    // Endpoints that address data memory rather than a register.
    function automatic logic is_mem(reg_type r);
        return (r == REG_MX) || (r == REG_MY) || (r == REG_MSP) || (r == REG_MN);
    endfunction

endpackage

interface regs_xfer_sequencer_if #(parameter int IMMED_W = 4) ();
    import regs_xfer_pkg::*;

    logic                 xfer_valid;
    logic                 xfer_ready;
    reg_type              xfer_src;
    reg_type              xfer_dst;
    logic [IMMED_W-1:0]   xfer_immed;
    logic                 stall;
    microcode_cycle       current_cycle;
    reg_type              bus_input_selector;
    reg_type              bus_output_selector;
    logic [IMMED_W-1:0]   immed;
    logic                 busy;
    logic                 xfer_done;
    logic                 bad_dst;

    modport master (
        output xfer_valid, xfer_src, xfer_dst, xfer_immed, stall,
        input  xfer_ready, current_cycle, bus_input_selector, bus_output_selector,
               immed, busy, xfer_done, bad_dst
    );

    modport slave (
        input  xfer_valid, xfer_src, xfer_dst, xfer_immed, stall,
        output xfer_ready, current_cycle, bus_input_selector, bus_output_selector,
               immed, busy, xfer_done, bad_dst
    );

endinterface

// File: rtl/regs_xfer_sequencer.sv
// Register-transfer sequencer: buffers micro-ops in a small FIFO and plays each
// out as a FETCH->WRITE slot toward the register/bus file. All outputs registered.
// Optional feature macro: SEQ_MEM_HAZARD_BUBBLE_EN -- inserts one idle cycle
// between a memory-target write and a following memory-source fetch.

module regs_xfer_sequencer
    import regs_xfer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int IMMED_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regs_xfer_sequencer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        reg_type            src;
        reg_type            dst;
        logic [IMMED_W-1:0] immed;
    } xfer_t;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;

    xfer_t              mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic               empty, full_d, push, pop, hazard;
    xfer_t              head;

    state_t             state_q, state_d;
    microcode_cycle     cycle_q, cycle_d;
    reg_type            src_q, src_d, dst_q, dst_d;
    logic [IMMED_W-1:0] imm_q, imm_d;
    logic               ready_q, busy_q, busy_d, done_q, done_d, bad_q, bad_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = bus.xfer_valid & ready_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign bad_d = push & ((bus.xfer_dst == REG_ALU) | (bus.xfer_dst == REG_IMM));

    // dst_q still holds the op in its WRITE slot, i.e. the last issued dst.
`ifdef SEQ_MEM_HAZARD_BUBBLE_EN
    assign hazard = is_mem(dst_q) & is_mem(head.src);
`else
    assign hazard = 1'b0;
`endif

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign busy_d   = (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);

    // Slot sequencing and next values of the registered bus drive.
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        src_d   = src_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (!bus.stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_WRITE;
                    done_d  = 1'b1;
                end
                S_WRITE: begin
                    if (!empty && !hazard) begin
                        pop     = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            unique case (state_d)
                S_FETCH: cycle_d = CYCLE_REG_FETCH;
                S_WRITE: cycle_d = CYCLE_REG_WRITE;
                default: begin
                    cycle_d = CYCLE_NONE;
                    src_d   = REG_IMM;
                    dst_d   = REG_IMM;
                    imm_d   = '0;
                end
            endcase

            if (pop) begin
                src_d = head.src;
                dst_d = head.dst;
                imm_d = head.immed;
            end
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{src: bus.xfer_src, dst: bus.xfer_dst,
                                                immed: bus.xfer_immed};
    end

    // State, pointers and all registered outputs; reset aborts any slot in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cycle_q  <= CYCLE_NONE;
            src_q    <= REG_IMM;
            dst_q    <= REG_IMM;
            imm_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            imm_q    <= imm_d;
            ready_q  <= !full_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.xfer_ready          = ready_q;
    assign bus.current_cycle       = cycle_q;
    assign bus.bus_input_selector  = src_q;
    assign bus.bus_output_selector = dst_q;
    assign bus.immed               = imm_q;
    assign bus.busy                = busy_q;
    assign bus.xfer_done           = done_q;
    assign bus.bad_dst             = bad_q;

endmodule

// File: tb/tb_regs_xfer_sequencer.sv
// Bench for regs_xfer_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based transaction model.
module tb_regs_xfer_sequencer;
    import regs_xfer_pkg::*;

    localparam int DEPTH = 4;
`ifdef SEQ_MEM_HAZARD_BUBBLE_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic clk, reset_n;
    regs_xfer_sequencer_if #(.IMMED_W(4)) bus ();

    regs_xfer_sequencer #(.DEPTH(DEPTH), .IMMED_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        reg_type    src;
        reg_type    dst;
        logic [3:0] imm;
    } op_t;

    // Reference model: pending ops in a queue plus the expected visible outputs.
    op_t            mq[$];
    microcode_cycle m_cycle;
    reg_type        m_src, m_dst;
    logic [3:0]     m_imm;
    logic           m_done, m_bad, m_busy, m_ready;

    int n_cmp = 0, n_err = 0;
    int n_write, n_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mem_ep(reg_type r);
        return r == REG_MX || r == REG_MY || r == REG_MSP || r == REG_MN;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_cycle = CYCLE_NONE; m_src = REG_IMM; m_dst = REG_IMM; m_imm = 4'h0;
        m_done = 0; m_bad = 0; m_busy = 0; m_ready = 0;
    endtask

    // One clock of the behavioural rules: a slot is FETCH then WRITE, the next
    // queued op follows immediately unless stalled or a memory bubble is due.
    task automatic m_step(input logic v, input reg_type s, input reg_type d,
                          input logic [3:0] im, input logic st, output logic acc);
        bit bubble;
        op_t o;
        acc    = v && m_ready;
        m_done = 0;
        if (!st) begin
            if (m_cycle == CYCLE_REG_FETCH) begin
                m_cycle = CYCLE_REG_WRITE;
                m_done  = 1;
            end else begin
                bubble = HAZ && (m_cycle == CYCLE_REG_WRITE) && mem_ep(m_dst) &&
                         (mq.size() > 0) && mem_ep(mq[0].src);
                if (mq.size() > 0 && !bubble) begin
                    o = mq.pop_front();
                    m_cycle = CYCLE_REG_FETCH;
                    m_src = o.src; m_dst = o.dst; m_imm = o.imm;
                end else begin
                    m_cycle = CYCLE_NONE;
                    m_src = REG_IMM; m_dst = REG_IMM; m_imm = 4'h0;
                end
            end
        end
        if (acc) mq.push_back('{src: s, dst: d, imm: im});
        m_bad   = acc && (d == REG_ALU || d == REG_IMM);
        m_ready = mq.size() < DEPTH;
        m_busy  = (mq.size() > 0) || (m_cycle != CYCLE_NONE);
    endtask

    task automatic check_outputs();
        chk("cycle",  32'(bus.current_cycle),       32'(m_cycle));
        chk("src",    32'(bus.bus_input_selector),  32'(m_src));
        chk("dst",    32'(bus.bus_output_selector), 32'(m_dst));
        chk("immed",  32'(bus.immed),               32'(m_imm));
        chk("done",   32'(bus.xfer_done),           32'(m_done));
        chk("bad",    32'(bus.bad_dst),             32'(m_bad));
        chk("busy",   32'(bus.busy),                32'(m_busy));
        chk("ready",  32'(bus.xfer_ready),          32'(m_ready));
        if (bus.current_cycle == CYCLE_REG_WRITE) n_write++;
        if (bus.xfer_done) n_done++;
    endtask

    // Drive inputs for one cycle, compare mid-cycle, advance the model at the edge.
    task automatic tick(input logic v, input reg_type s, input reg_type d,
                        input logic [3:0] im, input logic st, output logic acc);
        bus.xfer_valid = v; bus.xfer_src = s; bus.xfer_dst = d;
        bus.xfer_immed = im; bus.stall = st;
        @(negedge clk);
        check_outputs();
        acc = 1'b0;
        if (!reset_n) m_reset();
        else m_step(v, s, d, im, st, acc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(0, REG_A, REG_A, 4'h0, 0, a);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, st;
        int stall_cnt;
        reset_n = 1'b0;
        bus.xfer_valid = 0; bus.xfer_src = REG_A; bus.xfer_dst = REG_A;
        bus.xfer_immed = 0; bus.stall = 0;
        m_reset();
        tick(0, REG_A, REG_A, 4'h0, 1, acc);
        tick(0, REG_A, REG_A, 4'h0, 0, acc);
        reset_n = 1'b1;

        // Single op A->B.
        idle(1);
        n_write = 0; n_done = 0;
        tick(1, REG_A, REG_B, 4'h0, 0, acc);
        idle(5);
        chk("single_done_cnt", 32'(n_done), 32'd1);

        // Five pushes under stall: fifth held until the stall lifts.
        for (int i = 0; i < 5; i++) begin
            acc = 0;
            for (int t = 0; t < 20 && !acc; t++)
                tick(1, reg_type'(i), reg_type'(i + 1), 4'(i), (i < 4 || t < 3), acc);
            chk("push_accept", 32'(acc), 32'd1);
        end
        idle(14);

        // Back-to-back IMM->XL, XL->A.
        n_done = 0;
        tick(1, REG_IMM, REG_XL, 4'h5, 0, acc);
        tick(1, REG_XL, REG_A, 4'h6, 0, acc);
        idle(6);
        chk("b2b_done_cnt", 32'(n_done), 32'd2);

        // Stall held through WRITE for three cycles.
        n_write = 0; n_done = 0; stall_cnt = 0;
        tick(1, REG_A, REG_XH, 4'h3, 0, acc);
        for (int i = 0; i < 12; i++) begin
            st = (m_cycle == CYCLE_REG_WRITE) && (stall_cnt < 3);
            if (st) stall_cnt++;
            tick(0, REG_A, REG_A, 4'h0, st, acc);
        end
        chk("stall_write_len", 32'(n_write), 32'd4);
        chk("stall_done_cnt", 32'(n_done), 32'd1);

        // Illegal destination still plays out.
        n_done = 0;
        tick(1, REG_B, REG_ALU, 4'h9, 0, acc);
        idle(5);
        chk("bad_dst_slot", 32'(n_done), 32'd1);

        // Memory write followed by memory read.
        tick(1, REG_A, REG_MX, 4'h1, 0, acc);
        tick(1, REG_MX, REG_B, 4'h2, 0, acc);
        idle(7);

        // Reset asserted while a slot is in FETCH with more ops queued.
        tick(1, REG_A, REG_B, 4'h1, 0, acc);
        tick(1, REG_B, REG_XL, 4'h2, 0, acc);
        chk("pre_reset_fetch", 32'(bus.current_cycle), 32'(CYCLE_REG_FETCH));
        bus.xfer_valid = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_async_cycle", 32'(bus.current_cycle), 32'(CYCLE_NONE));
        chk("rst_async_src",   32'(bus.bus_input_selector), 32'(REG_IMM));
        chk("rst_async_dst",   32'(bus.bus_output_selector), 32'(REG_IMM));
        chk("rst_async_busy",  32'(bus.busy), 32'd0);
        m_reset();
        tick(0, REG_A, REG_A, 4'h0, 0, acc);
        reset_n = 1'b1;
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            tick(($urandom_range(0, 99) < 60), reg_type'($urandom_range(0, 13)),
                 reg_type'($urandom_range(0, 13)), 4'($urandom),
                 ($urandom_range(0, 99) < 20), acc);
        idle(20);
        chk("drain_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
